// File: rtl/rob_multiport.sv
// Reorder buffer with in-order allocate/retire and multi-port out-of-order write-back.
// Ports:
//   clk_in/rstn_in/rdy_in          clock, async active-low reset, global enable
//   alloc_*                        dispatcher allocation (kind, rd, pc); ready/tag/count out
//   wb_*                           WB_PORTS result buses (value, addr, redirect)
//   lk_*                           two combinational operand lookups
//   reg_*                          registered commit pulse to the register file
//   st_*                           store commit request/ack handshake
//   flush_out/redirect_pc_out      registered pipeline flush pulse and restart pc
//   ld_chk_*                       combinational older-store check and forwarding
module rob_multiport #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic                        clk_in,
  input  logic                        rstn_in,
  input  logic                        rdy_in,
  input  logic                        alloc_valid_in,
  input  logic [1:0]                  alloc_kind_in,
  input  logic [4:0]                  alloc_rd_in,
  input  logic [XLEN-1:0]             alloc_pc_in,
  output logic                        alloc_ready_out,
  output logic [IDX_W-1:0]            alloc_tag_out,
  output logic [IDX_W:0]              count_out,
  input  logic [WB_PORTS-1:0]         wb_valid_in,
  input  logic [WB_PORTS*IDX_W-1:0]   wb_tag_in,
  input  logic [WB_PORTS*XLEN-1:0]    wb_value_in,
  input  logic [WB_PORTS*XLEN-1:0]    wb_addr_in,
  input  logic [WB_PORTS-1:0]         wb_redirect_in,
  input  logic [2*IDX_W-1:0]          lk_tag_in,
  output logic [1:0]                  lk_ready_out,
  output logic [2*XLEN-1:0]           lk_value_out,
  output logic                        reg_wr_en_out,
  output logic [4:0]                  reg_rd_out,
  output logic [IDX_W-1:0]            reg_tag_out,
  output logic [XLEN-1:0]             reg_value_out,
  output logic                        st_req_out,
  input  logic                        st_ack_in,
  output logic [XLEN-1:0]             st_addr_out,
  output logic [XLEN-1:0]             st_data_out,
  output logic                        flush_out,
  output logic [XLEN-1:0]             redirect_pc_out,
  input  logic                        ld_chk_en_in,
  input  logic [IDX_W-1:0]            ld_chk_tag_in,
  input  logic [XLEN-1:0]             ld_chk_addr_in,
  output logic                        ld_chk_hit_out,
  output logic                        ld_chk_fwd_valid_out,
  output logic [XLEN-1:0]             ld_chk_fwd_data_out
);

  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam logic [1:0]  K_REG   = 2'd0;
  localparam logic [1:0]  K_BR    = 2'd1;
  localparam logic [1:0]  K_ST    = 2'd2;
  localparam logic [1:0]  K_JMP   = 2'd3;
  localparam logic [XLEN-1:0] IO_ADDR = XLEN'(32'h0003_0000);

  typedef enum logic {ST_IDLE, ST_REQ} st_state_e;

  st_state_e            st_state_q, st_state_d;
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     busy_q, busy_d, rdy_q, rdy_d, redir_q, redir_d;
  logic [1:0]           kind_q  [DEPTH];
  logic [1:0]           kind_d  [DEPTH];
  logic [4:0]           rd_q    [DEPTH];
  logic [4:0]           rd_d    [DEPTH];
  logic [XLEN-1:0]      value_q [DEPTH];
  logic [XLEN-1:0]      value_d [DEPTH];
  logic [XLEN-1:0]      addr_q  [DEPTH];
  logic [XLEN-1:0]      addr_d  [DEPTH];

  logic                 reg_wr_en_q, reg_wr_en_d, st_req_q, st_req_d, flush_q, flush_d;
  logic [4:0]           reg_rd_q, reg_rd_d;
  logic [IDX_W-1:0]     reg_tag_q, reg_tag_d;
  logic [XLEN-1:0]      reg_value_q, reg_value_d, st_addr_q, st_addr_d;
  logic [XLEN-1:0]      st_data_q, st_data_d, redirect_pc_q, redirect_pc_d;
  logic                 retire_c, flush_c, alloc_c, head_ok_c;

  // The instruction pc is carried by the dispatcher but not needed at commit.
  logic unused_pc_c;
  assign unused_pc_c = ^alloc_pc_in;

  assign alloc_ready_out = (count_q != CNT_W'(DEPTH));
  assign alloc_tag_out   = tail_q;
  assign count_out       = count_q;
  assign reg_wr_en_out   = reg_wr_en_q;
  assign reg_rd_out      = reg_rd_q;
  assign reg_tag_out     = reg_tag_q;
  assign reg_value_out   = reg_value_q;
  assign st_req_out      = st_req_q;
  assign st_addr_out     = st_addr_q;
  assign st_data_out     = st_data_q;
  assign flush_out       = flush_q;
  assign redirect_pc_out = redirect_pc_q;
  assign head_ok_c       = (count_q != '0) && rdy_q[head_q];

  // Next-state: retire/store FSM, flush, write-back, allocation.
  always_comb begin
    st_state_d    = st_state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    busy_d        = busy_q;
    rdy_d         = rdy_q;
    redir_d       = redir_q;
    kind_d        = kind_q;
    rd_d          = rd_q;
    value_d       = value_q;
    addr_d        = addr_q;
    reg_wr_en_d   = 1'b0;
    flush_d       = 1'b0;
    reg_rd_d      = reg_rd_q;
    reg_tag_d     = reg_tag_q;
    reg_value_d   = reg_value_q;
    st_req_d      = st_req_q;
    st_addr_d     = st_addr_q;
    st_data_d     = st_data_q;
    redirect_pc_d = redirect_pc_q;
    retire_c      = 1'b0;
    flush_c       = 1'b0;
    alloc_c       = 1'b0;

    if (rdy_in) begin
      if (head_ok_c) begin
        unique case (kind_q[head_q])
          K_REG, K_JMP: begin
            reg_wr_en_d = 1'b1;
            reg_rd_d    = rd_q[head_q];
            reg_tag_d   = head_q;
            reg_value_d = value_q[head_q];
            if (kind_q[head_q] == K_JMP) flush_c = 1'b1;
            else                         retire_c = 1'b1;
          end
          K_BR: begin
            if (redir_q[head_q]) flush_c = 1'b1;
            else                 retire_c = 1'b1;
          end
          default: begin
            if (st_state_q == ST_IDLE) begin
              st_state_d = ST_REQ;
              st_req_d   = 1'b1;
              st_addr_d  = addr_q[head_q];
              st_data_d  = value_q[head_q];
            end else if (st_ack_in) begin
              st_state_d = ST_IDLE;
              st_req_d   = 1'b0;
              retire_c   = 1'b1;
            end
          end
        endcase
      end

      if (flush_c) begin
        flush_d       = 1'b1;
        redirect_pc_d = addr_q[head_q];
        busy_d        = '0;
        rdy_d         = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
      end else begin
        // Ascending port order makes the highest-index port win on equal tags.
        for (int p = 0; p < WB_PORTS; p++) begin
          logic [IDX_W-1:0] wt;
          wt = wb_tag_in[p*IDX_W +: IDX_W];
          if (wb_valid_in[p] && busy_q[wt]) begin
            rdy_d[wt]   = 1'b1;
            value_d[wt] = wb_value_in[p*XLEN +: XLEN];
            addr_d[wt]  = wb_addr_in[p*XLEN +: XLEN];
            redir_d[wt] = wb_redirect_in[p];
          end
        end
        if (retire_c) begin
          busy_d[head_q] = 1'b0;
          rdy_d[head_q]  = 1'b0;
          head_d         = head_q + IDX_W'(1);
        end
        alloc_c = alloc_valid_in && alloc_ready_out;
        if (alloc_c) begin
          busy_d[tail_q]  = 1'b1;
          rdy_d[tail_q]   = 1'b0;
          redir_d[tail_q] = 1'b0;
          kind_d[tail_q]  = alloc_kind_in;
          rd_d[tail_q]    = alloc_rd_in;
          tail_d          = tail_q + IDX_W'(1);
        end
        count_d = count_q + CNT_W'(alloc_c) - CNT_W'(retire_c);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      st_state_q    <= ST_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      rdy_q         <= '0;
      redir_q       <= '0;
      kind_q        <= '{default: '0};
      rd_q          <= '{default: '0};
      value_q       <= '{default: '0};
      addr_q        <= '{default: '0};
      reg_wr_en_q   <= 1'b0;
      reg_rd_q      <= '0;
      reg_tag_q     <= '0;
      reg_value_q   <= '0;
      st_req_q      <= 1'b0;
      st_addr_q     <= '0;
      st_data_q     <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      st_state_q    <= st_state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      rdy_q         <= rdy_d;
      redir_q       <= redir_d;
      kind_q        <= kind_d;
      rd_q          <= rd_d;
      value_q       <= value_d;
      addr_q        <= addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_q      <= reg_rd_d;
      reg_tag_q     <= reg_tag_d;
      reg_value_q   <= reg_value_d;
      st_req_q      <= st_req_d;
      st_addr_q     <= st_addr_d;
      st_data_q     <= st_data_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Operand lookup: same-cycle write-back bypass first, then stored result.
  always_comb begin
    lk_ready_out = '0;
    lk_value_out = '0;
    for (int k = 0; k < 2; k++) begin
      logic [IDX_W-1:0] lt;
      lt = lk_tag_in[k*IDX_W +: IDX_W];
      lk_ready_out[k]              = busy_q[lt] && rdy_q[lt];
      lk_value_out[k*XLEN +: XLEN] = value_q[lt];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_in[p] && busy_q[lt] && (wb_tag_in[p*IDX_W +: IDX_W] == lt)) begin
          lk_ready_out[k]              = 1'b1;
          lk_value_out[k*XLEN +: XLEN] = wb_value_in[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Load check: age is the offset from head; forward from the youngest older match.
  always_comb begin
    logic [IDX_W-1:0] lim, off, best_off;
    logic             found;
    ld_chk_hit_out       = 1'b0;
    ld_chk_fwd_valid_out = 1'b0;
    ld_chk_fwd_data_out  = '0;
    lim                  = ld_chk_tag_in - head_q;
    off                  = '0;
    best_off             = '0;
    found                = 1'b0;
    if (ld_chk_en_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = IDX_W'(i) - head_q;
        if ((off < lim) && busy_q[i] && rdy_q[i] && (kind_q[i] == K_ST) &&
            (addr_q[i] == ld_chk_addr_in) && (!found || (off > best_off))) begin
          found               = 1'b1;
          best_off            = off;
          ld_chk_fwd_data_out = value_q[i];
        end
      end
      ld_chk_hit_out       = found;
      ld_chk_fwd_valid_out = found;
      // IO loads must wait until they are the oldest instruction.
      if ((ld_chk_addr_in == IO_ADDR) && (ld_chk_tag_in != head_q)) begin
        ld_chk_hit_out       = 1'b1;
        ld_chk_fwd_valid_out = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: fill/full, dual-port write-back, commit,
// enable freeze, store handshake, branch flush, load forwarding and async reset.
module tb_rob_multiport;

  localparam int unsigned DEPTH = 16, IDX_W = 4, WB_PORTS = 2, XLEN = 32;

  logic                      clk_in = 1'b0;
  logic                      rstn_in;
  logic                      rdy_in;
  logic                      alloc_valid_in;
  logic [1:0]                alloc_kind_in;
  logic [4:0]                alloc_rd_in;
  logic [XLEN-1:0]           alloc_pc_in;
  logic                      alloc_ready_out;
  logic [IDX_W-1:0]          alloc_tag_out;
  logic [IDX_W:0]            count_out;
  logic [WB_PORTS-1:0]       wb_valid_in;
  logic [WB_PORTS*IDX_W-1:0] wb_tag_in;
  logic [WB_PORTS*XLEN-1:0]  wb_value_in;
  logic [WB_PORTS*XLEN-1:0]  wb_addr_in;
  logic [WB_PORTS-1:0]       wb_redirect_in;
  logic [2*IDX_W-1:0]        lk_tag_in;
  logic [1:0]                lk_ready_out;
  logic [2*XLEN-1:0]         lk_value_out;
  logic                      reg_wr_en_out;
  logic [4:0]                reg_rd_out;
  logic [IDX_W-1:0]          reg_tag_out;
  logic [XLEN-1:0]           reg_value_out;
  logic                      st_req_out;
  logic                      st_ack_in;
  logic [XLEN-1:0]           st_addr_out;
  logic [XLEN-1:0]           st_data_out;
  logic                      flush_out;
  logic [XLEN-1:0]           redirect_pc_out;
  logic                      ld_chk_en_in;
  logic [IDX_W-1:0]          ld_chk_tag_in;
  logic [XLEN-1:0]           ld_chk_addr_in;
  logic                      ld_chk_hit_out;
  logic                      ld_chk_fwd_valid_out;
  logic [XLEN-1:0]           ld_chk_fwd_data_out;

  int n_checks = 0;
  int n_errors = 0;

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .XLEN(XLEN)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
    .alloc_valid_in(alloc_valid_in), .alloc_kind_in(alloc_kind_in),
    .alloc_rd_in(alloc_rd_in), .alloc_pc_in(alloc_pc_in),
    .alloc_ready_out(alloc_ready_out), .alloc_tag_out(alloc_tag_out), .count_out(count_out),
    .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
    .wb_addr_in(wb_addr_in), .wb_redirect_in(wb_redirect_in),
    .lk_tag_in(lk_tag_in), .lk_ready_out(lk_ready_out), .lk_value_out(lk_value_out),
    .reg_wr_en_out(reg_wr_en_out), .reg_rd_out(reg_rd_out), .reg_tag_out(reg_tag_out),
    .reg_value_out(reg_value_out),
    .st_req_out(st_req_out), .st_ack_in(st_ack_in), .st_addr_out(st_addr_out),
    .st_data_out(st_data_out), .flush_out(flush_out), .redirect_pc_out(redirect_pc_out),
    .ld_chk_en_in(ld_chk_en_in), .ld_chk_tag_in(ld_chk_tag_in), .ld_chk_addr_in(ld_chk_addr_in),
    .ld_chk_hit_out(ld_chk_hit_out), .ld_chk_fwd_valid_out(ld_chk_fwd_valid_out),
    .ld_chk_fwd_data_out(ld_chk_fwd_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change only at posedge+1; registered outputs are sampled there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; alloc_valid_in = 1'b0; alloc_kind_in = '0; alloc_rd_in = '0;
    alloc_pc_in = '0; wb_valid_in = '0; wb_tag_in = '0; wb_value_in = '0;
    wb_addr_in = '0; wb_redirect_in = '0; lk_tag_in = '0; st_ack_in = 1'b0;
    ld_chk_en_in = 1'b0; ld_chk_tag_in = '0; ld_chk_addr_in = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn_in = 1'b0;
    tick();
    rstn_in = 1'b1;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] rd);
    alloc_valid_in = 1'b1; alloc_kind_in = kind; alloc_rd_in = rd;
    alloc_pc_in = XLEN'(32'h1000) + XLEN'(rd);
    tick();
    alloc_valid_in = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [IDX_W-1:0] t, input logic [XLEN-1:0] v,
                        input logic [XLEN-1:0] a, input logic r);
    wb_valid_in[p] = 1'b1;
    wb_tag_in[p*IDX_W +: IDX_W] = t;
    wb_value_in[p*XLEN +: XLEN] = v;
    wb_addr_in[p*XLEN +: XLEN] = a;
    wb_redirect_in[p] = r;
  endtask

  task automatic ld_check(input logic [IDX_W-1:0] t, input logic [XLEN-1:0] a,
                          input logic hit, input logic fv, input logic [XLEN-1:0] d, input string nm);
    ld_chk_en_in = 1'b1; ld_chk_tag_in = t; ld_chk_addr_in = a;
    #1;
    chk({nm, "_hit"}, 64'(ld_chk_hit_out), 64'(hit));
    chk({nm, "_fwdv"}, 64'(ld_chk_fwd_valid_out), 64'(fv));
    if (fv) chk({nm, "_fwdd"}, 64'(ld_chk_fwd_data_out), 64'(d));
    ld_chk_en_in = 1'b0;
  endtask

  initial begin
    idle();
    rstn_in = 1'b0;
    #1;
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_ready", 64'(alloc_ready_out), 64'd1);
    chk("rst_tag", 64'(alloc_tag_out), 64'd0);
    chk("rst_pulses", 64'({reg_wr_en_out, st_req_out, flush_out}), 64'd0);
    tick();
    rstn_in = 1'b1;

    // Fill all entries with reg-writes, then try one more.
    for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i));
    chk("full_count", 64'(count_out), 64'd16);
    chk("full_ready", 64'(alloc_ready_out), 64'd0);
    alloc(2'd0, 5'd20);
    chk("full_ovf_count", 64'(count_out), 64'd16);
    chk("full_ovf_tag", 64'(alloc_tag_out), 64'd0);

    // Tag 3 on both ports: port 1 wins, visible through the bypass too.
    set_wb(0, 4'd3, 32'hA, 32'h0, 1'b0);
    set_wb(1, 4'd3, 32'hB, 32'h0, 1'b0);
    lk_tag_in = {4'd5, 4'd3};
    #1;
    chk("lk_byp_rdy", 64'(lk_ready_out), 64'b01);
    chk("lk_byp_val", 64'(lk_value_out[31:0]), 64'hB);
    tick();
    idle();
    lk_tag_in = {4'd5, 4'd3};
    #1;
    chk("lk_ent_rdy", 64'(lk_ready_out), 64'b01);
    chk("lk_ent_val", 64'(lk_value_out[31:0]), 64'hB);
    set_wb(0, 4'd0, 32'h10, 32'h0, 1'b0);
    set_wb(1, 4'd1, 32'h11, 32'h0, 1'b0);
    tick();
    idle();
    set_wb(0, 4'd2, 32'h12, 32'h0, 1'b0);
    tick();
    idle();
    chk("ret0_en", 64'(reg_wr_en_out), 64'd1);
    chk("ret0_tag", 64'(reg_tag_out), 64'd0);
    chk("ret0_val", 64'(reg_value_out), 64'h10);
    chk("ret0_count", 64'(count_out), 64'd15);
    tick();
    chk("ret1_val", 64'(reg_value_out), 64'h11);
    tick();
    chk("ret2_val", 64'(reg_value_out), 64'h12);
    tick();
    chk("ret3_en", 64'(reg_wr_en_out), 64'd1);
    chk("ret3_rd", 64'(reg_rd_out), 64'd3);
    chk("ret3_val", 64'(reg_value_out), 64'hB);
    chk("ret3_count", 64'(count_out), 64'd12);
    tick();
    chk("ret4_none", 64'(reg_wr_en_out), 64'd0);

    // Enable low: write-back and allocation are both frozen out.
    rdy_in = 1'b0;
    set_wb(0, 4'd4, 32'h99, 32'h0, 1'b0);
    alloc_valid_in = 1'b1;
    tick();
    idle();
    lk_tag_in = {4'd0, 4'd4};
    #1;
    chk("frz_count", 64'(count_out), 64'd12);
    chk("frz_tag", 64'(alloc_tag_out), 64'd0);
    chk("frz_lk", 64'(lk_ready_out[0]), 64'd0);

    // Store handshake with a 3-cycle-late ack.
    do_reset();
    alloc(2'd2, 5'd0);
    set_wb(0, 4'd0, 32'h55, 32'h100, 1'b0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_req", 64'(st_req_out), 64'd1);
      chk("st_addr", 64'(st_addr_out), 64'h100);
      chk("st_data", 64'(st_data_out), 64'h55);
      chk("st_count", 64'(count_out), 64'd1);
    end
    st_ack_in = 1'b1;
    tick();
    st_ack_in = 1'b0;
    chk("st_done_req", 64'(st_req_out), 64'd0);
    chk("st_done_count", 64'(count_out), 64'd0);

    // Mispredicted branch at tag 2 flushes; same-cycle allocation is dropped.
    do_reset();
    alloc(2'd0, 5'd1);
    alloc(2'd0, 5'd2);
    alloc(2'd1, 5'd0);
    set_wb(0, 4'd2, 32'h0, 32'h400, 1'b1);
    set_wb(1, 4'd0, 32'h1, 32'h0, 1'b0);
    tick();
    idle();
    set_wb(0, 4'd1, 32'h2, 32'h0, 1'b0);
    tick();
    idle();
    chk("br_ret0_count", 64'(count_out), 64'd2);
    tick();
    chk("br_ret1_count", 64'(count_out), 64'd1);
    alloc_valid_in = 1'b1;
    tick();
    idle();
    chk("fl_pulse", 64'(flush_out), 64'd1);
    chk("fl_pc", 64'(redirect_pc_out), 64'h400);
    chk("fl_count", 64'(count_out), 64'd0);
    chk("fl_tag", 64'(alloc_tag_out), 64'd0);
    chk("fl_noreg", 64'(reg_wr_en_out), 64'd0);
    tick();
    chk("fl_end", 64'(flush_out), 64'd0);

    // Older stores at tags 1 and 4 to 0x200; tag 0 stays unwritten so nothing retires.
    do_reset();
    alloc(2'd0, 5'd1);
    alloc(2'd2, 5'd0);
    alloc(2'd0, 5'd2);
    alloc(2'd0, 5'd3);
    alloc(2'd2, 5'd0);
    alloc(2'd0, 5'd4);
    alloc(2'd0, 5'd5);
    set_wb(0, 4'd1, 32'h33, 32'h200, 1'b0);
    set_wb(1, 4'd4, 32'h77, 32'h200, 1'b0);
    tick();
    idle();
    ld_check(4'd6, 32'h200, 1'b1, 1'b1, 32'h77, "ld_young");
    ld_check(4'd3, 32'h200, 1'b1, 1'b1, 32'h33, "ld_mid");
    ld_check(4'd1, 32'h200, 1'b0, 1'b0, 32'h0, "ld_self");
    ld_check(4'd6, 32'h300, 1'b0, 1'b0, 32'h0, "ld_miss");
    ld_check(4'd6, 32'h30000, 1'b1, 1'b0, 32'h0, "ld_io");
    ld_check(4'd0, 32'h30000, 1'b0, 1'b0, 32'h0, "ld_io_head");

    // Asynchronous reset in the middle of a store request.
    do_reset();
    alloc(2'd2, 5'd0);
    set_wb(0, 4'd0, 32'h66, 32'h104, 1'b0);
    tick();
    idle();
    tick();
    chk("ar_req_before", 64'(st_req_out), 64'd1);
    #2;
    rstn_in = 1'b0;
    #1;
    chk("ar_req", 64'(st_req_out), 64'd0);
    chk("ar_count", 64'(count_out), 64'd0);
    tick();
    rstn_in = 1'b1;
    tick();
    tick();
    chk("ar_idle", 64'(st_req_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
